// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, loaded-mask indices.
package alu_pkg;

   localparam int OP_W = 6;

   localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
   localparam logic [OP_W-1:0] OP_AND = 6'b100100;
   localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
   localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
   localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
   localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam int LD_A  = 0;
   localparam int LD_B  = 1;
   localparam int LD_OP = 2;
   localparam int LD_W  = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, carry-out, signed overflow and illegal-opcode detect.
module alu_core
   import alu_pkg::*;
#(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
) (
   input  logic [NB_DATA-1:0] a_i,
   input  logic [NB_DATA-1:0] b_i,
   input  logic [NB_OP-1:0]   op_i,
   output logic [NB_DATA-1:0] result_o,
   output logic               carry_o,
   output logic               ovf_o,
   output logic               illegal_o
);

   localparam int MSB = NB_DATA - 1;
   localparam logic [NB_DATA:0] SH_LIM = (NB_DATA + 1)'(NB_DATA);

   logic [NB_DATA:0] ext;
   logic             big_sh;

   // Shift amounts at or beyond the width saturate explicitly.
   assign big_sh = ({1'b0, b_i} >= SH_LIM);

   always_comb begin
      ext       = '0;
      result_o  = '0;
      carry_o   = 1'b0;
      ovf_o     = 1'b0;
      illegal_o = 1'b0;
      case (op_i)
         NB_OP'(OP_ADD): begin
            ext      = {1'b0, a_i} + {1'b0, b_i};
            result_o = ext[MSB:0];
            carry_o  = ext[NB_DATA];
            ovf_o    = (a_i[MSB] == b_i[MSB]) && (ext[MSB] != a_i[MSB]);
         end
         NB_OP'(OP_SUB): begin
            // carry-out of A + ~B + 1: set means no borrow
            ext      = {1'b0, a_i} + {1'b0, ~b_i} + (NB_DATA + 1)'(1);
            result_o = ext[MSB:0];
            carry_o  = ext[NB_DATA];
            ovf_o    = (a_i[MSB] != b_i[MSB]) && (ext[MSB] != a_i[MSB]);
         end
         NB_OP'(OP_AND): result_o = a_i & b_i;
         NB_OP'(OP_OR):  result_o = a_i | b_i;
         NB_OP'(OP_XOR): result_o = a_i ^ b_i;
         NB_OP'(OP_NOR): result_o = ~(a_i | b_i);
         NB_OP'(OP_SRA): result_o = big_sh ? {NB_DATA{a_i[MSB]}}
                                           : $unsigned($signed(a_i) >>> b_i);
         NB_OP'(OP_SRL): result_o = big_sh ? '0 : (a_i >> b_i);
         default:        illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: button-edge operand/opcode loading, LOAD/EXEC/DONE FSM, registered result.
// Optional result flags are built only when ALU_SEQ_FLAGS_EN is defined.
module alu_seq
   import alu_pkg::*;
#(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic [NB_DATA-1:0] i_sw,
   input  logic               i_btn_a,
   input  logic               i_btn_b,
   input  logic               i_btn_op,
   input  logic               i_valid,
   output logic [NB_DATA-1:0] o_leds,
   output logic               o_valid,
   output logic               o_err,
   output logic               o_zero,
   output logic               o_carry,
   output logic               o_ovf
);

   logic btn_a_q, btn_b_q, btn_op_q, valid_in_q;
   logic edge_a, edge_b, edge_op, edge_vld, edge_ld;

   logic [NB_DATA-1:0] a_q, b_q, leds_q, leds_d;
   logic [NB_OP-1:0]   op_q;
   logic [LD_W-1:0]    ld_q, ld_d;
   state_e             state_q, state_d;
   logic               valid_q, valid_d, err_q, err_d, exec_ok;

   logic [NB_DATA-1:0] core_res;
   logic               core_ill;
`ifdef ALU_SEQ_FLAGS_EN
   logic               core_carry, core_ovf;
`endif

   assign edge_a   = i_btn_a  & ~btn_a_q;
   assign edge_b   = i_btn_b  & ~btn_b_q;
   assign edge_op  = i_btn_op & ~btn_op_q;
   assign edge_vld = i_valid  & ~valid_in_q;
   assign edge_ld  = edge_a | edge_b | edge_op;

   always_comb begin
      ld_d         = ld_q;
      ld_d[LD_A]   = ld_q[LD_A]  | edge_a;
      ld_d[LD_B]   = ld_q[LD_B]  | edge_b;
      ld_d[LD_OP]  = ld_q[LD_OP] | edge_op;
   end

   alu_core #(
      .NB_DATA (NB_DATA),
      .NB_OP   (NB_OP)
   ) u_core (
      .a_i       (a_q),
      .b_i       (b_q),
      .op_i      (op_q),
      .result_o  (core_res),
`ifdef ALU_SEQ_FLAGS_EN
      .carry_o   (core_carry),
      .ovf_o     (core_ovf),
`else
      .carry_o   (),
      .ovf_o     (),
`endif
      .illegal_o (core_ill)
   );

   always_comb begin
      state_d = state_q;
      leds_d  = leds_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      exec_ok = 1'b0;
      case (state_q)
         S_EXEC: begin
            state_d = S_DONE;
            if (core_ill) begin
               err_d = 1'b1;
            end else begin
               leds_d  = core_res;
               valid_d = 1'b1;
               exec_ok = 1'b1;
            end
         end
         default: begin
            // A valid edge that coincides with a load edge is dropped; the load wins.
            if (edge_vld && !edge_ld) begin
               if (&ld_q) state_d = S_EXEC;
               else       err_d   = 1'b1;
            end else if (edge_ld && (state_q == S_DONE)) begin
               state_d = S_LOAD;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         btn_a_q    <= 1'b0;
         btn_b_q    <= 1'b0;
         btn_op_q   <= 1'b0;
         valid_in_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         ld_q       <= '0;
         state_q    <= S_LOAD;
         leds_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         btn_a_q    <= i_btn_a;
         btn_b_q    <= i_btn_b;
         btn_op_q   <= i_btn_op;
         valid_in_q <= i_valid;
         if (edge_a)  a_q  <= i_sw;
         if (edge_b)  b_q  <= i_sw;
         if (edge_op) op_q <= i_sw[NB_OP-1:0];
         ld_q       <= ld_d;
         state_q    <= state_d;
         leds_q     <= leds_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   assign o_leds  = leds_q;
   assign o_valid = valid_q;
   assign o_err   = err_q;

`ifdef ALU_SEQ_FLAGS_EN
   logic zero_q, carry_q, ovf_q;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (exec_ok) begin
         zero_q  <= (core_res == '0);
         carry_q <= core_carry;
         ovf_q   <= core_ovf;
      end
   end

   assign o_zero  = zero_q;
   assign o_carry = carry_q;
   assign o_ovf   = ovf_q;
`else
   assign o_zero  = 1'b0;
   assign o_carry = 1'b0;
   assign o_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed plan items plus random operations vs. an arithmetic model.
module tb_alu_seq;

   localparam int NB_DATA = 8;
   localparam int NB_OP   = 6;
`ifdef ALU_SEQ_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               i_rst = 1'b1;
   logic [NB_DATA-1:0] i_sw = '0;
   logic               i_btn_a = 1'b0, i_btn_b = 1'b0, i_btn_op = 1'b0, i_valid = 1'b0;
   logic [NB_DATA-1:0] o_leds;
   logic               o_valid, o_err, o_zero, o_carry, o_ovf;

   int n_chk = 0;
   int n_pass = 0;

   // reference state
   int m_a, m_b, m_op, m_leds;
   bit m_ld [3];
   bit m_z, m_c, m_v;

   alu_seq #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
      .clk      (clk),
      .i_rst    (i_rst),
      .i_sw     (i_sw),
      .i_btn_a  (i_btn_a),
      .i_btn_b  (i_btn_b),
      .i_btn_op (i_btn_op),
      .i_valid  (i_valid),
      .o_leds   (o_leds),
      .o_valid  (o_valid),
      .o_err    (o_err),
      .o_zero   (o_zero),
      .o_carry  (o_carry),
      .o_ovf    (o_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void ref_alu(input int a, input int b, input int op,
                                   output int r, output bit c, output bit v, output bit ill);
      int sa, sb, s;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      r = 0; c = 0; v = 0; ill = 0;
      case (op)
         32'h20: begin s = a + b; r = s % 256; c = (s >= 256); v = (sa + sb > 127) || (sa + sb < -128); end
         32'h22: begin s = a + (255 - b) + 1; r = s % 256; c = (s >= 256); v = (sa - sb > 127) || (sa - sb < -128); end
         32'h24: r = a & b;
         32'h25: r = a | b;
         32'h26: r = a ^ b;
         32'h27: r = 255 - (a | b);
         32'h03: r = (b >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> b) & 255);
         32'h02: r = (b >= 8) ? 0 : (a >> b);
         default: ill = 1;
      endcase
   endfunction

   task automatic model_reset();
      m_a = 0; m_b = 0; m_op = 0; m_leds = 0;
      m_z = 0; m_c = 0; m_v = 0;
      for (int i = 0; i < 3; i++) m_ld[i] = 0;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      model_reset();
   endtask

   // which: 0=A 1=B 2=OP
   task automatic load(input int which, input int v);
      i_sw = v[7:0];
      case (which)
         0: i_btn_a = 1'b1;
         1: i_btn_b = 1'b1;
         default: i_btn_op = 1'b1;
      endcase
      tick();
      i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0;
      case (which)
         0: m_a = v & 255;
         1: m_b = v & 255;
         default: m_op = v & 63;
      endcase
      m_ld[which] = 1;
      tick();
   endtask

   task automatic check_outs(input string tag);
      chk({tag, "_leds"}, o_leds, m_leds);
      chk({tag, "_zero"}, o_zero, FLAGS ? m_z : 0);
      chk({tag, "_carry"}, o_carry, FLAGS ? m_c : 0);
      chk({tag, "_ovf"}, o_ovf, FLAGS ? m_v : 0);
   endtask

   task automatic do_exec(input string tag);
      int r; bit c, v, ill, all;
      all = m_ld[0] && m_ld[1] && m_ld[2];
      ref_alu(m_a, m_b, m_op, r, c, v, ill);
      i_valid = 1'b1;
      tick();
      chk({tag, "_err_n1"}, o_err, !all);
      chk({tag, "_vld_n1"}, o_valid, 0);
      i_valid = 1'b0;
      tick();
      if (all && !ill) begin
         m_leds = r; m_z = (r == 0); m_c = c; m_v = v;
      end
      chk({tag, "_vld_n2"}, o_valid, all && !ill);
      chk({tag, "_err_n2"}, o_err, all && ill);
      check_outs(tag);
      tick();
      chk({tag, "_vld_n3"}, o_valid, 0);
      chk({tag, "_err_n3"}, o_err, 0);
   endtask

   task automatic run_op(input string tag, input int a, input int b, input int op);
      load(0, a);
      load(1, b);
      load(2, op);
      do_exec(tag);
   endtask

   initial begin
      int ops [8] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h26, 32'h03, 32'h02, 32'h27};
      int bad [4] = '{32'h00, 32'h01, 32'h3F, 32'h21};
      int op;

      model_reset();
      tick();
      do_reset();
      check_outs("reset");
      chk("reset_valid", o_valid, 0);
      chk("reset_err", o_err, 0);

      // partial load -> rejected
      load(0, 8'h05);
      load(2, 32'h20);
      do_exec("partial");

      load(1, 8'h03);
      do_exec("add_5_3");
      run_op("illegal_3f", 8'h05, 8'h03, 32'h3F);
      run_op("sub_3_5", 8'h03, 8'h05, 32'h22);
      run_op("add_ovf", 8'h7F, 8'h01, 32'h20);
      run_op("sra_2", 8'h80, 8'h02, 32'h03);
      run_op("srl_2", 8'h80, 8'h02, 32'h02);
      run_op("sra_9", 8'h80, 8'h09, 32'h03);
      run_op("srl_9", 8'h80, 8'h09, 32'h02);
      run_op("sub_eq", 8'h44, 8'h44, 32'h22);

      // valid edge coinciding with a load edge is ignored, load still applies
      run_op("pre_coinc", 8'h10, 8'h01, 32'h20);
      i_sw = 8'h21; i_btn_a = 1'b1; i_valid = 1'b1;
      tick();
      chk("coinc_err_n1", o_err, 0);
      i_btn_a = 1'b0; i_valid = 1'b0;
      tick();
      chk("coinc_vld_n2", o_valid, 0);
      chk("coinc_err_n2", o_err, 0);
      chk("coinc_leds", o_leds, m_leds);
      m_a = 8'h21;
      tick();
      do_exec("post_coinc");

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) != 0) load(0, int'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) != 0) load(1, int'($urandom_range(0, 255)));
         if ($urandom_range(0, 7) == 0) op = bad[$urandom_range(0, 3)];
         else                           op = ops[$urandom_range(0, 7)];
         load(2, op);
         do_exec($sformatf("rnd%0d", i));
      end

      // reset while the FSM is in EXEC aborts the result
      run_op("pre_abort", 8'h05, 8'h03, 32'h20);
      i_valid = 1'b1;
      tick();
      i_rst = 1'b1;
      tick();
      model_reset();
      chk("abort_leds", o_leds, 0);
      chk("abort_vld", o_valid, 0);
      chk("abort_err", o_err, 0);
      i_rst = 1'b0; i_valid = 1'b0;
      tick();
      chk("abort_vld_late", o_valid, 0);
      do_exec("after_abort");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
